serial_fsm_ctrl: RTL and testbench

Sequencing controller for the team's 3-bit serial next-state/output core. It accepts a parallel word through a valid/ready handshake and shifts it LSB-first into a registered copy of the core's state. It accumulates the core's two Moore outputs over the word and returns the counts and the final core state through a second valid/ready handshake. The core state optionally persists across words, so a bit stream longer than one word can be processed as a series of words.

---
 rtl/serial_fsm_ctrl.sv | 111 +++++++++++
 tb/tb_serial_fsm_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_fsm_ctrl.sv
// Word-level sequencer for the 3-bit serial next-state/output core.
// A word is shifted LSB-first through the core and the Moore output counts are returned.
module serial_fsm_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_restart,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] y1_count,
  output logic [CNT_W-1:0] y0_count,
  output logic [2:0]       out_state
);

  localparam int unsigned IDX_W = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [2:0]       s_q, s_d;
  logic [CNT_W-1:0] y1_cnt_q, y1_cnt_d;
  logic [CNT_W-1:0] y0_cnt_q, y0_cnt_d;
  logic             in_ready_q, out_valid_q;

  // Serial core: next state from (s, x), Moore outputs from s alone.
  logic       x;
  logic [2:0] n;
  logic       y1, y0;

  always_comb begin
    x    = shift_q[0];
    n[2] = (s_q[2] & ~s_q[0]) | (s_q[1] & ~s_q[0] & ~x);
    n[1] = (~x & (s_q[0] | s_q[2])) | (s_q[1] & ~s_q[0] & x);
    n[0] = x;
    y1   = s_q[0] & (s_q[2] ^ s_q[1]);
    y0   = s_q[1] & s_q[0];
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    s_d      = s_q;
    y1_cnt_d = y1_cnt_q;
    y0_cnt_d = y0_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          shift_d  = in_data;
          idx_d    = '0;
          y1_cnt_d = '0;
          y0_cnt_d = '0;
          if (in_restart) s_d = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        // Counts never exceed WIDTH, which CNT_W is sized to hold.
        y1_cnt_d = y1_cnt_q + CNT_W'(y1);
        y0_cnt_d = y0_cnt_q + CNT_W'(y0);
        s_d      = n;
        shift_d  = shift_q >> 1;
        idx_d    = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(WIDTH - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      idx_q       <= '0;
      s_q         <= '0;
      y1_cnt_q    <= '0;
      y0_cnt_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      s_q         <= s_d;
      y1_cnt_q    <= y1_cnt_d;
      y0_cnt_q    <= y0_cnt_d;
      // Handshake flags are flopped from the next state so no input reaches them combinationally.
      in_ready_q  <= (state_d == ST_IDLE);
      out_valid_q <= (state_d == ST_DONE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y1_count  = y1_cnt_q;
  assign y0_count  = y0_cnt_q;
  assign out_state = s_q;

endmodule

// File: tb/tb_serial_fsm_ctrl.sv
// Scoreboard bench for serial_fsm_ctrl: a word-level reference model predicts each response,
// and a negedge monitor compares whatever the DUT presents.
module tb_serial_fsm_ctrl;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 4;

  logic          clk, rst;
  logic          in_valid, in_ready, in_restart;
  logic [W-1:0]  in_data;
  logic          out_valid, out_ready;
  logic [CW-1:0] y1_count, y0_count;
  logic [2:0]    out_state;

  serial_fsm_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_restart(in_restart),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y1_count  (y1_count),
    .y0_count  (y0_count),
    .out_state (out_state)
  );

  typedef struct {
    logic [CW-1:0] y1;
    logic [CW-1:0] y0;
    logic [2:0]    st;
    int            acc;
  } exp_t;

  exp_t exp_q[$];
  exp_t last;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic [2:0] m_s = 3'b000;
  bit   rst_chk = 0;
  bit   idle_chk = 0;
  bit   prev_ov = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference core, taken directly from the next-state/output equations.
  function automatic logic [2:0] core_next(input logic [2:0] s, input logic xb);
    logic [2:0] r;
    r[2] = (s[2] & ~s[0]) | (s[1] & ~s[0] & ~xb);
    r[1] = (~xb & (s[0] | s[2])) | (s[1] & ~s[0] & xb);
    r[0] = xb;
    return r;
  endfunction

  function automatic exp_t model_word(input logic [W-1:0] d, input logic [2:0] s0);
    exp_t e;
    int c1 = 0, c0 = 0;
    logic [2:0] s = s0;
    for (int i = 0; i < int'(W); i++) begin
      if (s[0] && (s[2] != s[1])) c1++;
      if (s[1] && s[0]) c0++;
      s = core_next(s, d[i]);
    end
    e.y1 = CW'(c1);
    e.y0 = CW'(c0);
    e.st = s;
    e.acc = 0;
    return e;
  endfunction

  // Monitor / scoreboard: all sampling on the falling edge.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_chk) begin
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_state", out_state, 0);
      chk("rst_y1", y1_count, 0);
      chk("rst_y0", y0_count, 0);
      rst_chk = 0;
      idle_chk = 0;
    end else if (idle_chk) begin
      chk("idle_in_ready", in_ready, 1);
      chk("idle_out_valid", out_valid, 0);
      idle_chk = 0;
    end
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", out_valid, 0);
      end else begin
        e = exp_q[0];
        if (!prev_ov) chk("latency", cyc - e.acc, W);
        chk("y1_count", y1_count, e.y1);
        chk("y0_count", y0_count, e.y0);
        chk("out_state", out_state, e.st);
        chk("in_ready_in_done", in_ready, 0);
      end
    end
    prev_ov = out_valid;
    if (rst) begin
      exp_q.delete();
      m_s = 3'b000;
      rst_chk = 1;
      prev_ov = 0;
    end else begin
      if (out_valid && out_ready && exp_q.size() != 0) begin
        last = exp_q.pop_front();
        idle_chk = 1;
      end
      if (in_valid && in_ready) begin
        e = model_word(in_data, in_restart ? 3'b000 : m_s);
        e.acc = cyc + 1;
        m_s = e.st;
        exp_q.push_back(e);
      end
    end
  end

  // Called at posedge+#1; returns at posedge+#1 just after the accept edge.
  task automatic send(input logic [W-1:0] d, input logic r);
    int t = 0;
    in_data = d;
    in_restart = r;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data = W'($urandom);
    in_restart = 1'(($urandom));
  endtask

  // Waits for out_valid, stalls, then completes the output handshake.
  task automatic recv(input int stall, input bit poke_in);
    int t = 0;
    @(negedge clk);
    while (!out_valid && t < 100) begin
      t++;
      @(negedge clk);
    end
    if (!out_valid) begin
      chk("out_valid_timeout", out_valid, 1);
      return;
    end
    @(posedge clk);
    #1;
    if (poke_in) begin
      in_valid = 1'b1;
      in_data = W'($urandom);
    end
    repeat (stall) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic directed(input logic [W-1:0] d, input logic r, input int stall,
                          input logic [CW-1:0] ey1, input logic [CW-1:0] ey0,
                          input logic [2:0] est, input string tag);
    send(d, r);
    recv(stall, stall > 0);
    chk({tag, "_y1"}, last.y1, ey1);
    chk({tag, "_y0"}, last.y0, ey0);
    chk({tag, "_state"}, last.st, est);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_restart = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    directed(8'h55, 1'b1, 0, 3, 3, 3'b010, "h55_restart");
    directed(8'h55, 1'b0, 0, 4, 4, 3'b010, "h55_continue");
    directed(8'hAA, 1'b1, 0, 2, 2, 3'b011, "hAA_restart");
    directed(8'hFF, 1'b1, 0, 0, 0, 3'b001, "hFF_restart");
    directed(8'h00, 1'b1, 0, 0, 0, 3'b000, "h00_restart");
    directed(8'h55, 1'b1, 5, 3, 3, 3'b010, "backpressure");

    // Reset in the middle of RUN, then continue without restart.
    send(8'hAA, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    directed(8'h55, 1'b0, 0, 3, 3, 3'b010, "after_midrun_rst");

    for (int i = 0; i < 40; i++) begin
      send(W'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 7) == 0) begin
        k = $urandom_range(0, W + 1);
        repeat (k) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
      end else begin
        recv($urandom_range(0, 3), $urandom_range(0, 1) == 1);
      end
    end

    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
